// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the divider and multiplier:
// field widths, special encodings, classification helpers and the divider FSM states.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int DIV_ITER = 26;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DIVIDE,
        NORM,
        ROUND,
        DONE
    } div_state_e;

    function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == '1) && (m != '0);
    endfunction

    function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == '1) && (m == '0);
    endfunction

    // Denormals are flushed, so a zero exponent alone means zero.
    function automatic logic is_zero(input logic [EXP_W-1:0] e);
        return (e == '0);
    endfunction

    function automatic logic [31:0] signed_inf(input logic s);
        return s ? NEG_INF : POS_INF;
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'd0};
    endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Start/operand/result handshake shared by the single-precision arithmetic units.
interface fp_divider_if;
    logic        ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        done;
    logic        busy;

    modport master (output ready, op1, op2, input res, done, busy);
    modport slave  (input ready, op1, op2, output res, done, busy);
endinterface

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per clock for DIV_ITER clocks after start.
// valid pulses for one cycle once quotient and sticky hold the final result.
module fp_mant_divider
    import fp32_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MAN_W:0]      dividend_i,
    input  logic [MAN_W:0]      divisor_i,
    output logic [DIV_ITER-1:0] quot_o,
    output logic                sticky_o,
    output logic                valid_o
);
    logic                run_q, run_d;
    logic                valid_q, valid_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [MAN_W+1:0]    rem_q, rem_d;
    logic [MAN_W:0]      div_q, div_d;
    logic [DIV_ITER-1:0] q_q, q_d;
    logic                ge;
    logic [MAN_W:0]      diff;

    // rem < 2*div always, so a true difference fits in the lower MAN_W+1 bits.
    assign ge   = (rem_q >= {1'b0, div_q});
    assign diff = rem_q[MAN_W:0] - div_q;

    always_comb begin
        run_d   = run_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = {1'b0, dividend_i};
            div_d = divisor_i;
            q_d   = '0;
        end else if (run_q) begin
            q_d   = {q_q[DIV_ITER-2:0], ge};
            rem_d = ge ? {diff, 1'b0} : {rem_q[MAN_W:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            run_q   <= run_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        div_q <= div_d;
        q_q   <= q_d;
    end

    assign quot_o   = q_q;
    assign sticky_o = |rem_q;
    assign valid_o  = valid_q;
endmodule

// File: rtl/fp_divider.sv
// IEEE754 single-precision divider, res = op1 / op2, multi-cycle with ready/done handshake.
// This FSM owns special cases, normalisation and round-to-nearest-even.
module fp_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fp_divider_if.slave bus
);
    div_state_e state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] res_q, res_d;
    logic        done_q, done_d;

    logic              sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;
    logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W-1:0]  ma_q, ma_d, mb_q, mb_d, man_q, man_d;
    logic signed [9:0] exp_q, exp_d;
    logic              guard_q, guard_d, stk_q, stk_d;

    logic                mdiv_start;
    logic [DIV_ITER-1:0] mdiv_quot;
    logic                mdiv_sticky, mdiv_valid;
    logic                nan_any, invalid, inf_res, zero_res;

    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                               input logic [MAN_W-1:0] m, input logic g,
                                               input logic st);
        logic              inc;
        logic [MAN_W:0]    sum;
        logic signed [9:0] e_r;
        inc = g & (st | m[0]);
        sum = {1'b0, m} + {{MAN_W{1'b0}}, inc};
        e_r = e + $signed({9'd0, sum[MAN_W]});
        if (e_r >= 10'sd255)
            return signed_inf(s);
        else if (e_r <= 10'sd0)
            return signed_zero(s);
        else
            return {s, e_r[EXP_W-1:0], sum[MAN_W-1:0]};
    endfunction

    assign nan_any  = is_nan(ea_q, ma_q) || is_nan(eb_q, mb_q);
    assign invalid  = (is_inf(ea_q, ma_q) && is_inf(eb_q, mb_q)) || (is_zero(ea_q) && is_zero(eb_q));
    assign inf_res  = is_inf(ea_q, ma_q) || is_zero(eb_q);
    assign zero_res = is_zero(ea_q) || is_inf(eb_q, mb_q);

    fp_mant_divider u_mant (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mdiv_start),
        .dividend_i ({1'b1, ma_q}),
        .divisor_i  ({1'b1, mb_q}),
        .quot_o     (mdiv_quot),
        .sticky_o   (mdiv_sticky),
        .valid_o    (mdiv_valid)
    );

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        res_d      = res_q;
        done_d     = 1'b0;
        mdiv_start = 1'b0;
        sa_d = sa_q;   sb_d = sb_q;   sign_d = sign_q;
        ea_d = ea_q;   eb_d = eb_q;
        ma_d = ma_q;   mb_d = mb_q;   man_d  = man_q;
        exp_d = exp_q; guard_d = guard_q; stk_d = stk_q;
        case (state_q)
            IDLE: if (bus.ready) state_d = LOAD;
            LOAD: begin
                sa_d    = bus.op1[31];
                ea_d    = bus.op1[30:23];
                ma_d    = (bus.op1[30:23] == '0) ? '0 : bus.op1[22:0];
                sb_d    = bus.op2[31];
                eb_d    = bus.op2[30:23];
                mb_d    = (bus.op2[30:23] == '0) ? '0 : bus.op2[22:0];
                state_d = CHECK;
            end
            CHECK: begin
                sign_d = sa_q ^ sb_q;
                if (nan_any || invalid || inf_res || zero_res) begin
                    if (nan_any || invalid) res_d = QNAN;
                    else if (inf_res)       res_d = signed_inf(sa_q ^ sb_q);
                    else                    res_d = signed_zero(sa_q ^ sb_q);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    exp_d      = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'(BIAS);
                    iter_d     = '0;
                    mdiv_start = 1'b1;
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(DIV_ITER - 1)) state_d = NORM;
            end
            NORM: if (mdiv_valid) begin
                // Quotient in (0.5, 2): an unset top bit means one left shift.
                if (mdiv_quot[DIV_ITER-1]) begin
                    {man_d, guard_d} = mdiv_quot[DIV_ITER-2:1];
                    stk_d            = mdiv_quot[0] | mdiv_sticky;
                end else begin
                    {man_d, guard_d} = mdiv_quot[DIV_ITER-3:0];
                    stk_d            = mdiv_sticky;
                    exp_d            = exp_q - 10'sd1;
                end
                state_d = ROUND;
            end
            ROUND: begin
                res_d   = round_pack(sign_q, exp_q, man_q, guard_q, stk_q);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        sa_q <= sa_d;   sb_q <= sb_d;   sign_q <= sign_d;
        ea_q <= ea_d;   eb_q <= eb_d;
        ma_q <= ma_d;   mb_q <= mb_d;   man_q  <= man_d;
        exp_q <= exp_d; guard_q <= guard_d; stk_q <= stk_d;
    end

    assign bus.res  = res_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed vector table, handshake/reset sequences and random
// operands checked against an exact-quotient rounding model.
module tb_fp_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_divider_if bus ();

    fp_divider dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    // Exact quotient by wide integer division, then round-to-nearest-even.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output bit special);
        bit s, nana, nanb, infa, infb, za, zb;
        int ea, eb, e, sh;
        longint unsigned ma, mb, n, r, low, half, sig;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nana = (ea == 255) && (a[22:0] != 0);
        nanb = (eb == 255) && (b[22:0] != 0);
        infa = (ea == 255) && (a[22:0] == 0);
        infb = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        s = a[31] ^ b[31];
        special = 1'b1;
        if (nana || nanb) return 32'h7FC00000;
        if ((infa && infb) || (za && zb)) return 32'h7FC00000;
        if (infa || zb) return {s, 8'hFF, 23'd0};
        if (za || infb) return {s, 31'd0};
        special = 1'b0;
        ma = 64'h800000 | 64'(a[22:0]);
        mb = 64'h800000 | 64'(b[22:0]);
        n = (ma << 40) / mb;
        r = (ma << 40) % mb;
        if (n >= (64'd1 << 40)) begin e = ea - eb + 127; sh = 17; end
        else begin e = ea - eb + 126; sh = 16; end
        sig = n >> sh;
        low = n & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (low > half || (low == half && (r != 0 || sig[0]))) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
            1: v[30:23] = 8'h00;
            2: v[30:23] = 8'($urandom_range(1, 20));
            3: v[30:23] = 8'($urandom_range(235, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation and wait (bounded) for done; lat=0 means it never came.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r,
                         output int lat, output logic busy_at_done, output logic done_after,
                         output logic busy_after);
        @(negedge clk);
        bus.ready = 1'b1;
        bus.op1   = a;
        bus.op2   = b;
        @(posedge clk); #1;
        bus.ready = 1'b0;
        lat = 0;
        r = '0;
        busy_at_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                r = bus.res;
                busy_at_done = bus.busy;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    initial begin
        logic [31:0] r, r1, r2, held, expr;
        logic        bad, bd, da, ba;
        int          lat, dcount, d1, d2, seen;
        bit          sp;

        vecs[0]  = '{32'h40A00000, 32'h40000000, 32'h40200000, 31};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 31};
        vecs[2]  = '{32'h40000000, 32'h3F800000, 32'h40000000, 31};
        vecs[3]  = '{32'h42C86666, 32'h80000000, 32'hFF800000, 3};
        vecs[4]  = '{32'hFF800000, 32'h45185B75, 32'hFF800000, 3};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 3};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 3};
        vecs[7]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 31};
        vecs[8]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 31};
        vecs[9]  = '{32'hFF7FFFFF, 32'h00800000, 32'hFF800000, 31};
        vecs[10] = '{32'h00800000, 32'hFF7FFFFF, 32'h80000000, 31};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3};
        vecs[12] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 3};
        vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3};
        vecs[14] = '{32'h00000001, 32'h3F800000, 32'h00000000, 3};
        vecs[15] = '{32'hBF800000, 32'h00400000, 32'hFF800000, 3};

        bus.ready = 1'b0;
        bus.op1   = '0;
        bus.op2   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset res", bus.res, 32'h0);
        chk("reset done", 32'(bus.done), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, r, lat, bd, da, ba);
            chk($sformatf("vec%0d res", i), r, vecs[i].r);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d busy at done", i), 32'(bd), 32'h1);
            chk($sformatf("vec%0d single done", i), 32'(da), 32'h0);
            chk($sformatf("vec%0d idle after", i), 32'(ba), 32'h0);
        end

        // ready re-pulsed while busy (cycle 5) and in DONE (cycle 31), then accepted in IDLE (cycle 32)
        @(negedge clk);
        bus.ready = 1'b1;
        bus.op1   = 32'h40A00000;
        bus.op2   = 32'h40000000;
        @(posedge clk); #1;
        bus.ready = 1'b0;
        dcount = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0; held = '0;
        for (int c = 1; c <= 70; c++) begin
            if (bus.done) begin
                dcount++;
                if (dcount == 1) begin d1 = c; r1 = bus.res; end
                else begin d2 = c; r2 = bus.res; end
            end
            if (c == 40) held = bus.res;
            bus.ready = (c == 5 || c == 31 || c == 32);
            if (c == 5 || c == 31) begin bus.op1 = 32'h3F800000; bus.op2 = 32'h40400000; end
            if (c == 32) begin bus.op1 = 32'h40000000; bus.op2 = 32'h3F800000; end
            @(posedge clk); #1;
        end
        bus.ready = 1'b0;
        chk("hs done count", 32'(dcount), 32'd2);
        chk("hs first done cycle", 32'(d1), 32'd31);
        chk("hs first res", r1, 32'h40200000);
        chk("hs res held", held, 32'h40200000);
        chk("hs second done cycle", 32'(d2), 32'd63);
        chk("hs second res", r2, 32'h40000000);

        // Reset at cycle 15 of an operation
        @(negedge clk);
        bus.ready = 1'b1;
        bus.op1   = 32'h3F800000;
        bus.op2   = 32'h40400000;
        @(posedge clk); #1;
        bus.ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort res", bus.res, 32'h0);
        chk("abort done", 32'(bus.done), 32'h0);
        chk("abort busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("abort no done", 32'(seen), 32'd0);
        do_op(32'h3F800000, 32'h40400000, r, lat, bd, da, ba);
        chk("after abort res", r, 32'h3EAAAAAB);
        chk("after abort latency", 32'(lat), 32'd31);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = rnd_op();
            b = rnd_op();
            expr = ref_div(a, b, sp);
            do_op(a, b, r, lat, bd, da, ba);
            bad = (r !== expr);
            chk($sformatf("rand%0d %08h/%08h res", i, a, b), r, expr);
            chk($sformatf("rand%0d latency", i), 32'(lat), sp ? 32'd3 : 32'd31);
            if (bad) $display("  operands were %08h / %08h", a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end
endmodule
